adc_cmd_responder: RTL and testbench

- UART command/response engine for N ADC channels, parametrised in sample width, channel count and TX handshake timeout.
- Tracks the latest sample and a running unsigned peak per channel.
- Decodes one received opcode byte and streams a framed multi-byte response, MSB first, to the UART transmitter through a ready/write-enable handshake.
- Sits between the SPI channel front-ends and the UART block in the top level. It replaces the hard-wired single-byte max-value reply.

---
 rtl/adc_cmd_responder.sv | 195 +++++++++++++++++++
 tb/tb_adc_cmd_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_cmd_responder.sv
// adc_cmd_responder
//   UART command/response engine for NUM_CH ADC channels. Tracks the latest
//   sample and a running unsigned peak per channel. It decodes one opcode byte
//   received in IDLE and streams a framed response, MSB byte first, to the UART
//   transmitter through a tx_ready / tx_write_en handshake.
// Ports
//   clk, reset     system clock, asynchronous active-high reset
//   ch_data        packed samples, channel k at [k*DATA_W +: DATA_W]
//   ch_valid       per-channel new-sample strobe
//   rx_data        received opcode byte, qualified by the rx_ready strobe
//   tx_ready       UART TX idle level
//   tx_data        byte presented to the UART (held from LOAD to next LOAD)
//   tx_write_en    one-cycle load strobe to the UART
//   busy           FSM not in IDLE
//   drop_count     saturating count of opcodes ignored while busy
//   timeout_flag   sticky TX timeout flag, cleared by opcode 0xC0

// Per-channel latest/peak tracker
module adc_ch_track #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              valid,
  input  logic              clr,
  output logic [DATA_W-1:0] latest,
  output logic [DATA_W-1:0] peak
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latest <= '0;
      peak   <= '0;
    end else begin
      if (valid) latest <= sample;
      // A sample arriving with a clear becomes the new peak outright.
      if (valid && (clr || sample > peak)) peak <= sample;
      else if (clr)                        peak <= '0;
    end
  end
endmodule

module adc_cmd_responder #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 10,
  parameter int TX_TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ready,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_write_en,
  output logic                     busy,
  output logic [7:0]               drop_count,
  output logic                     timeout_flag
);
  localparam int BYTES = (DATA_W + 7) / 8;
  localparam int MAXB  = 1 + NUM_CH * BYTES;
  localparam int LEN_W = $clog2(MAXB + 1);
  localparam int TMO_W = $clog2(TX_TIMEOUT + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_LO, WAIT_HI} state_t;

  state_t                         state;
  logic [NUM_CH-1:0][DATA_W-1:0]  latest, peak;
  logic [MAXB-1:0][7:0]           fbuf, nbuf;
  logic [LEN_W-1:0]               len, nlen, idx;
  logic [TMO_W-1:0]               tmo_cnt;
  logic                           tmo_hit, accept, clr_pk;
  logic                           ch_ok, op_lat, op_pk, op_dump, op_clr;
  logic [CH_W-1:0]                sel;

  // ---- channel trackers ----
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    adc_ch_track #(.DATA_W(DATA_W)) u_trk (
      .clk    (clk),
      .reset  (reset),
      .sample (ch_data[k*DATA_W +: DATA_W]),
      .valid  (ch_valid[k]),
      .clr    (clr_pk),
      .latest (latest[k]),
      .peak   (peak[k])
    );
  end

  // ---- opcode decode ----
  assign accept  = (state == IDLE) && rx_ready;
  assign sel     = rx_data[CH_W-1:0];
  assign ch_ok   = ({2'b00, rx_data[5:0]} < 8'(NUM_CH));
  assign op_lat  = (rx_data[7:6] == 2'b00) && ch_ok;
  assign op_pk   = (rx_data[7:6] == 2'b01) && ch_ok;
  assign op_dump = (rx_data == 8'h80);
  assign op_clr  = (rx_data == 8'hC0);
  assign clr_pk  = accept && op_clr;

  // Byte j (0 = most significant) of a sample zero-extended to BYTES*8 bits
  function automatic logic [7:0] byte_of(input logic [DATA_W-1:0] s, input int j);
    logic [BYTES*8-1:0] ext;
    ext           = '0;
    ext[DATA_W-1:0] = s;
    return ext[(BYTES-1-j)*8 +: 8];
  endfunction

  // Candidate frame, captured into fbuf in the accept cycle so later samples
  // cannot disturb a response in flight.
  always_comb begin
    nbuf    = '0;
    nlen    = LEN_W'(2);
    nbuf[0] = rx_data;
    if (op_lat) begin
      for (int j = 0; j < BYTES; j++) nbuf[1+j] = byte_of(latest[sel], j);
      nlen = LEN_W'(1 + BYTES);
    end else if (op_pk) begin
      for (int j = 0; j < BYTES; j++) nbuf[1+j] = byte_of(peak[sel], j);
      nlen = LEN_W'(1 + BYTES);
    end else if (op_dump) begin
      for (int k = 0; k < NUM_CH; k++)
        for (int j = 0; j < BYTES; j++) nbuf[1+k*BYTES+j] = byte_of(latest[k], j);
      nlen = LEN_W'(MAXB);
    end else if (op_clr) begin
      nlen = LEN_W'(1);
    end else begin
      nbuf[0] = 8'hEE;
      nbuf[1] = rx_data;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_W'(TX_TIMEOUT - 1));

  // ---- response FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tx_data      <= '0;
      fbuf         <= '0;
      len          <= '0;
      idx          <= '0;
      tmo_cnt      <= '0;
      drop_count   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (rx_ready && state != IDLE && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      case (state)
        IDLE: if (rx_ready) begin
          fbuf  <= nbuf;
          len   <= nlen;
          idx   <= '0;
          state <= LOAD;
          if (op_clr) timeout_flag <= 1'b0;
        end
        LOAD: begin
          tx_data <= fbuf[idx];
          idx     <= idx + LEN_W'(1);
          tmo_cnt <= '0;
          state   <= SEND;
        end
        SEND: if (tx_ready) begin
          tmo_cnt <= '0;
          state   <= WAIT_LO;
        end else if (tmo_hit) begin
          timeout_flag <= 1'b1;
          state        <= IDLE;
        end else tmo_cnt <= tmo_cnt + TMO_W'(1);
        WAIT_LO: if (!tx_ready) begin
          tmo_cnt <= '0;
          state   <= WAIT_HI;
        end else if (tmo_hit) begin
          timeout_flag <= 1'b1;
          state        <= IDLE;
        end else tmo_cnt <= tmo_cnt + TMO_W'(1);
        WAIT_HI: if (tx_ready) begin
          tmo_cnt <= '0;
          state   <= (idx == len) ? IDLE : LOAD;
        end else if (tmo_hit) begin
          timeout_flag <= 1'b1;
          state        <= IDLE;
        end else tmo_cnt <= tmo_cnt + TMO_W'(1);
        default: state <= IDLE;
      endcase
    end
  end

  // The strobe is gated by tx_ready in the same cycle, so it can never fire
  // into a busy UART and still lands two cycles after the accepting rx_ready.
  // SEND is left on the same edge, which keeps it one cycle wide.
  assign tx_write_en = (state == SEND) && tx_ready;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_adc_cmd_responder.sv
module tb_adc_cmd_responder;
  localparam int NUM_CH = 4, DATA_W = 10, TX_TIMEOUT = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic [7:0]               rx_data;
  logic                     rx_ready;
  logic                     tx_ready;
  logic [7:0]               tx_data;
  logic                     tx_write_en;
  logic                     busy;
  logic [7:0]               drop_count;
  logic                     timeout_flag;

  adc_cmd_responder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_write_en(tx_write_en), .busy(busy),
    .drop_count(drop_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int         n_checks = 0, n_pass = 0, we_seen = 0;
  logic [7:0] exp_q[$];
  bit         uart_stuck = 1'b0;
  logic [9:0] mdl_lat[NUM_CH], mdl_pk[NUM_CH];

  typedef struct packed {
    logic [7:0]  op;
    logic [3:0]  n;
    logic [71:0] b;   // expected bytes, left-justified, first byte in [71:64]
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample(input int ch, input logic [9:0] v);
    ch_data[ch*DATA_W +: DATA_W] = v;
    ch_valid = 4'(1 << ch);
    tick();
    ch_valid = '0;
    mdl_lat[ch] = v;
    if (v > mdl_pk[ch]) mdl_pk[ch] = v;
  endtask

  task automatic issue(input logic [7:0] op);
    rx_data  = op;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  // Expected frame for a legal opcode, from the bench's channel model
  task automatic push_frame(input logic [7:0] op);
    exp_q.push_back(op);
    if (op == 8'h80) begin
      for (int k = 0; k < NUM_CH; k++) begin
        exp_q.push_back({6'b0, mdl_lat[k][9:8]});
        exp_q.push_back(mdl_lat[k][7:0]);
      end
    end else if (op[7:6] == 2'b00) begin
      exp_q.push_back({6'b0, mdl_lat[op[1:0]][9:8]});
      exp_q.push_back(mdl_lat[op[1:0]][7:0]);
    end else if (op[7:6] == 2'b01) begin
      exp_q.push_back({6'b0, mdl_pk[op[1:0]][9:8]});
      exp_q.push_back(mdl_pk[op[1:0]][7:0]);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 500) begin tick(); n++; end
    check({name, "_idle"}, 32'(busy), 0);
    check({name, "_drained"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_tx_data"}, 32'(tx_data), 0);
    check({name, "_tx_we"}, 32'(tx_write_en), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_drop"}, 32'(drop_count), 0);
    check({name, "_tmo"}, 32'(timeout_flag), 0);
  endtask

  // UART model: takes the byte, drops ready, raises it again a few cycles later
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_write_en) begin
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        while (uart_stuck) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // Scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (tx_write_en) begin
      we_seen++;
      check("we_while_ready", 32'(tx_ready), 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_byte: got %02h with no byte expected", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, d, it, we_before;
    reset = 1'b1; ch_data = '0; ch_valid = '0; rx_data = '0; rx_ready = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin mdl_lat[k] = '0; mdl_pk[k] = '0; end

    tbl[0]  = '{8'h02, 4'd3, 72'h02_02_A7_00_00_00_00_00_00};
    tbl[1]  = '{8'h41, 4'd3, 72'h41_03_FF_00_00_00_00_00_00};
    tbl[2]  = '{8'h01, 4'd3, 72'h01_00_05_00_00_00_00_00_00};
    tbl[3]  = '{8'h42, 4'd3, 72'h42_02_A7_00_00_00_00_00_00};
    tbl[4]  = '{8'h80, 4'd9, 72'h80_00_01_00_05_02_A7_00_04};
    tbl[5]  = '{8'h07, 4'd2, 72'hEE_07_00_00_00_00_00_00_00};
    tbl[6]  = '{8'h04, 4'd2, 72'hEE_04_00_00_00_00_00_00_00};
    tbl[7]  = '{8'h44, 4'd2, 72'hEE_44_00_00_00_00_00_00_00};
    tbl[8]  = '{8'h81, 4'd2, 72'hEE_81_00_00_00_00_00_00_00};
    tbl[9]  = '{8'hC0, 4'd1, 72'hC0_00_00_00_00_00_00_00_00};
    tbl[10] = '{8'h41, 4'd3, 72'h41_00_00_00_00_00_00_00_00};
    tbl[11] = '{8'h42, 4'd3, 72'h42_00_00_00_00_00_00_00_00};

    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Channel contents for the table: latest {1,5,2A7,4}, peak {1,3FF,2A7,4}
    sample(2, 10'h2A7);
    sample(1, 10'h100); sample(1, 10'h3FF); sample(1, 10'h005);
    sample(0, 10'h001); sample(3, 10'h004);

    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < int'(tbl[i].n); j++) exp_q.push_back(tbl[i].b[71-8*j -: 8]);
      issue(tbl[i].op);
      wait_idle($sformatf("vec%0d", i));
      if (tbl[i].op == 8'hC0) for (int k = 0; k < NUM_CH; k++) mdl_pk[k] = '0;
    end

    // Snapshot: a sample landing mid-dump must not change the frame
    sample(0, 10'd1); sample(1, 10'd2); sample(2, 10'd3); sample(3, 10'd4);
    push_frame(8'h80);
    issue(8'h80);
    repeat (3) tick();
    sample(0, 10'h3FF);
    wait_idle("snap");
    push_frame(8'h00);
    issue(8'h00);
    wait_idle("snap_after");

    // Drops while busy, then saturation
    exp_q.push_back(8'hEE); exp_q.push_back(8'h07);
    issue(8'h07);
    for (int i = 0; i < 3; i++) issue(8'h55);
    wait_idle("bad_op");
    check("drop3", 32'(drop_count), 3);
    d = 0; it = 0;
    while (d < 300 && it < 5000) begin
      it++;
      if (busy) begin issue(8'h5A); d++; end
      else begin push_frame(8'h80); issue(8'h80); end
    end
    check("drop_loop_done", 32'(d), 300);
    wait_idle("sat");
    check("drop_sat", 32'(drop_count), 255);

    // Timeout: UART never re-raises ready after the header byte
    uart_stuck = 1'b1;
    exp_q.push_back(8'h02);
    issue(8'h02);
    n = 0;
    while (tx_ready && n < 50) begin @(negedge clk); n++; end
    check("tmo_ready_fell", 32'(tx_ready), 0);
    m = 0;
    while (busy && m < 40) begin @(negedge clk); m++; end
    n_checks++;
    if (m >= 16 && m <= 18) n_pass++;
    else $display("FAIL timeout_cycles: busy fell after %0d cycles, required 16..18", m);
    check("tmo_flag", 32'(timeout_flag), 1);
    check("tmo_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
    uart_stuck = 1'b0;
    n = 0;
    while (!tx_ready && n < 50) begin @(negedge clk); n++; end
    tick();
    push_frame(8'h01);
    issue(8'h01);
    wait_idle("post_tmo");
    check("tmo_sticky", 32'(timeout_flag), 1);

    // Clear together with a ch3 sample; also first-byte latency
    exp_q.push_back(8'hC0);
    rx_data = 8'hC0; rx_ready = 1'b1;
    ch_data[3*DATA_W +: DATA_W] = 10'h123; ch_valid = 4'b1000;
    tick();
    rx_ready = 1'b0; ch_valid = '0;
    for (int k = 0; k < NUM_CH; k++) mdl_pk[k] = '0;
    mdl_pk[3] = 10'h123; mdl_lat[3] = 10'h123;
    check("clr_flag", 32'(timeout_flag), 0);
    tick();
    check("latency_we", 32'(tx_write_en), 1);
    check("latency_data", 32'(tx_data), 32'h0C0);
    wait_idle("clr");
    push_frame(8'h43);
    issue(8'h43);
    wait_idle("clr_sample_peak");
    push_frame(8'h41);
    issue(8'h41);
    wait_idle("clr_other_peak");

    // Async reset during byte 2 of a dump
    push_frame(8'h80);
    issue(8'h80);
    n = 0;
    while (exp_q.size() > 8 && n < 100) begin @(negedge clk); n++; end
    check("dump_byte1_seen", 32'(exp_q.size()), 8);
    repeat (6) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_vals("midrst");
    exp_q.delete();
    for (int k = 0; k < NUM_CH; k++) begin mdl_lat[k] = '0; mdl_pk[k] = '0; end
    we_before = we_seen;
    tick();
    reset = 1'b0;
    repeat (30) tick();
    check("no_we_after_rst", 32'(we_seen - we_before), 0);
    push_frame(8'h41);
    issue(8'h41);
    wait_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
